// File: rtl/mips_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer and its datapath siblings.
// Latency: none (definitions only). Backpressure: n/a.
// Consumers: controller, execute stage.
package mips_fsm_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_RF   = 3'd2,
    S_EX   = 3'd3,
    S_MA   = 3'd4,
    S_WB   = 3'd5,
    S_OUT  = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [5:0] OP_RFORM = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [1:0] {
    MEM_READ  = 2'b00,
    MEM_WRITE = 2'b01,
    MEM_IDLE  = 2'b10
  } mem_op_t;

endpackage

// File: rtl/mips_ctrl_perf_counters.sv
// Saturating 16-bit cycle and stall counters for the sequencer.
// Latency: counts appear one cycle after the qualifying cycle. Backpressure: none.
module mips_ctrl_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cycle_inc,
  input  logic        stall_inc,
  output logic [15:0] cycle_count,
  output logic [15:0] stall_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= 16'd0;
      stall_count <= 16'd0;
    end else begin
      if (cycle_inc && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
      if (stall_inc && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: rtl/mips_fsm_controller.sv
// Multi-cycle MIPS sequencer: IF/ID/RF/EX/MA/WB/OUT/HALT; counters under MIPS_CTRL_PERF_EN.
// Latency: 4 (branch), 6 (ALU), 7 (LW) cycles with immediate acks. Backpressure:
// holds in IF, MA and OUT until imem_ack, dmem_ack, out_ready respectively.
module mips_fsm_controller
  import mips_fsm_pkg::*;
#(
  parameter int MAX_INSTR = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  operation_code,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        out_ready,
  output logic [2:0]  current_state,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic [1:0]  mem_op,
  output logic        wb_sel,
  output logic        rf_write_en,
  output logic        result_valid,
  output logic        halted,
  output logic [7:0]  retired_count,
  output logic [15:0] cycle_count,
  output logic [15:0] stall_count
);

  state_t   state, state_nxt;
  mem_op_t  mem_op_s;
  logic     retire;
  logic [7:0] retired_next;
  logic     retire_hit;

  assign retired_next = retired_count + 8'd1;
  // An 8-bit count never equals 256, so that limit never halts.
  assign retire_hit   = (MAX_INSTR != 0) && (int'(retired_next) == MAX_INSTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IF;
      retired_count <= 8'd0;
    end else begin
      state <= state_nxt;
      if (retire) retired_count <= retired_next;
    end
  end

  always_comb begin
    state_nxt    = state;
    retire       = 1'b0;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    mem_op_s     = MEM_IDLE;
    wb_sel       = 1'b0;
    rf_write_en  = 1'b0;
    result_valid = 1'b0;
    halted       = 1'b0;
    case (state)
      S_IF: begin
        imem_req = run;
        if (run && imem_ack) state_nxt = S_ID;
      end
      S_ID: state_nxt = S_RF;
      S_RF: state_nxt = S_EX;
      S_EX: begin
        case (operation_code)
          OP_LW:              state_nxt = S_MA;
          OP_ADDIU, OP_RFORM: state_nxt = S_WB;
          default:            retire = 1'b1;
        endcase
      end
      S_MA: begin
        dmem_req = 1'b1;
        mem_op_s = MEM_READ;
        if (dmem_ack) state_nxt = S_WB;
      end
      S_WB: begin
        rf_write_en = 1'b1;
        wb_sel      = (operation_code == OP_LW);
        state_nxt   = S_OUT;
      end
      S_OUT: begin
        result_valid = 1'b1;
        if (out_ready) retire = 1'b1;
      end
      S_HALT: halted = 1'b1;
    endcase
    if (retire) state_nxt = retire_hit ? S_HALT : S_IF;
  end

  assign current_state = state;
  assign mem_op        = mem_op_s;
  assign ir_load       = imem_req & imem_ack;

`ifdef MIPS_CTRL_PERF_EN
  logic cycle_inc;
  logic stall_inc;

  assign cycle_inc = (state != S_HALT) && (run || state != S_IF);
  assign stall_inc = (state == S_IF  && run && !imem_ack) ||
                     (state == S_MA  && !dmem_ack)        ||
                     (state == S_OUT && !out_ready);

  mips_ctrl_perf_counters u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .cycle_inc   (cycle_inc),
    .stall_inc   (stall_inc),
    .cycle_count (cycle_count),
    .stall_count (stall_count)
  );
`else
  assign cycle_count = 16'd0;
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_mips_fsm_controller.sv
// Directed bench for mips_fsm_controller: one unlimited instance, one with MAX_INSTR=3.
module tb_mips_fsm_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rst_h_n = 1'b0;
  logic        run = 1'b0;
  logic [5:0]  operation_code = 6'b001001;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        out_ready = 1'b0;

  logic [2:0]  current_state, current_state_h;
  logic        imem_req, imem_req_h, ir_load, ir_load_h, dmem_req, dmem_req_h;
  logic [1:0]  mem_op, mem_op_h;
  logic        wb_sel, wb_sel_h, rf_write_en, rf_write_en_h;
  logic        result_valid, result_valid_h, halted, halted_h;
  logic [7:0]  retired_count, retired_count_h;
  logic [15:0] cycle_count, cycle_count_h, stall_count, stall_count_h;

  int n_pass = 0;
  int n_tot  = 0;
  int wr_pulses;
  int bad;

  always #5 clk = ~clk;

  mips_fsm_controller #(.MAX_INSTR(0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .operation_code(operation_code),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .out_ready(out_ready),
    .current_state(current_state), .imem_req(imem_req), .ir_load(ir_load),
    .dmem_req(dmem_req), .mem_op(mem_op), .wb_sel(wb_sel), .rf_write_en(rf_write_en),
    .result_valid(result_valid), .halted(halted), .retired_count(retired_count),
    .cycle_count(cycle_count), .stall_count(stall_count)
  );

  mips_fsm_controller #(.MAX_INSTR(3)) dut_h (
    .clk(clk), .rst_n(rst_h_n), .run(run), .operation_code(operation_code),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .out_ready(out_ready),
    .current_state(current_state_h), .imem_req(imem_req_h), .ir_load(ir_load_h),
    .dmem_req(dmem_req_h), .mem_op(mem_op_h), .wb_sel(wb_sel_h), .rf_write_en(rf_write_en_h),
    .result_valid(result_valid_h), .halted(halted_h), .retired_count(retired_count_h),
    .cycle_count(cycle_count_h), .stall_count(stall_count_h)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [2:0] seq_alu [6];
    logic [2:0] seq_br  [8];
    seq_alu = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd0};
    seq_br  = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(current_state), 0);
    chk("rst_mem_op", 32'(mem_op), 32'h2);
    chk("rst_outs", 32'({imem_req, ir_load, dmem_req, wb_sel, rf_write_en, result_valid, halted}), 0);
    chk("rst_retired", 32'(retired_count), 0);
    chk("rst_perf", 32'({cycle_count, stall_count}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ADDIU with immediate acks
    run = 1'b1; imem_ack = 1'b1; out_ready = 1'b1; operation_code = 6'b001001;
    #1;
    chk("addiu_if_state", 32'(current_state), 0);
    chk("addiu_imem_req", 32'(imem_req), 1);
    chk("addiu_ir_load", 32'(ir_load), 1);
    wr_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("addiu_seq", 32'(current_state), 32'(seq_alu[i]));
      wr_pulses += int'(rf_write_en);
    end
    run = 1'b0;
    chk("addiu_wr_pulses", wr_pulses, 1);
    chk("addiu_retired", 32'(retired_count), 1);
    #1;
    chk("idle_imem_req", 32'(imem_req), 0);
    chk("idle_ir_load", 32'(ir_load), 0);
    tick();
    chk("idle_hold_if", 32'(current_state), 0);

    // LW with dmem_ack late by 3 cycles
    operation_code = 6'b100011; run = 1'b1;
    tick();
    chk("lw_id", 32'(current_state), 1);
    run = 1'b0; imem_ack = 1'b0;
    tick(); tick(); tick();
    chk("lw_ma1", 32'(current_state), 4);
    chk("lw_dmem_req", 32'(dmem_req), 1);
    chk("lw_mem_op", 32'(mem_op), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_ma_hold", 32'(current_state), 4);
      chk("lw_ma_op", 32'(mem_op), 0);
    end
    dmem_ack = 1'b1;
    tick();
    chk("lw_wb", 32'(current_state), 5);
    chk("lw_wb_sel", 32'(wb_sel), 1);
    chk("lw_wb_wr", 32'(rf_write_en), 1);
    chk("lw_wb_mem_op", 32'(mem_op), 32'h2);
    dmem_ack = 1'b0;
    tick();
    chk("lw_out", 32'(current_state), 6);
    tick();
    chk("lw_done_if", 32'(current_state), 0);
    chk("lw_retired", 32'(retired_count), 2);
`ifdef MIPS_CTRL_PERF_EN
    chk("lw_stall", 32'(stall_count), 3);
    chk("lw_cycles", 32'(cycle_count), 16);
`else
    chk("lw_stall_off", 32'(stall_count), 0);
    chk("lw_cycles_off", 32'(cycle_count), 0);
`endif

    // BEQ then BNE from a fresh count
    rst_n = 1'b0;
    #1;
    chk("rst2_retired", 32'(retired_count), 0);
    rst_n = 1'b1;
    operation_code = 6'b000100; run = 1'b1; imem_ack = 1'b1; out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("br_seq", 32'(current_state), 32'(seq_br[i]));
      bad += int'(rf_write_en | result_valid);
      if (i == 3) operation_code = 6'b000101;
    end
    run = 1'b0;
    chk("br_no_wr_out", bad, 0);
    chk("br_retired", 32'(retired_count), 2);

    // Asynchronous reset during MA
    operation_code = 6'b100011; run = 1'b1;
    tick();
    run = 1'b0; imem_ack = 1'b0;
    tick(); tick(); tick();
    chk("mar_state", 32'(current_state), 4);
    chk("mar_dmem_req", 32'(dmem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mar_rst_state", 32'(current_state), 0);
    chk("mar_rst_dmem_req", 32'(dmem_req), 0);
    chk("mar_rst_retired", 32'(retired_count), 0);
    chk("mar_rst_mem_op", 32'(mem_op), 32'h2);
    rst_n = 1'b1;
    operation_code = 6'b001001; run = 1'b1; imem_ack = 1'b1; out_ready = 1'b1;
    #1;
    chk("restart_if", 32'(current_state), 0);
    tick();
    chk("restart_id", 32'(current_state), 1);

    // OUT backpressure; imem_ack during OUT is ignored
    run = 1'b0; imem_ack = 1'b0; out_ready = 1'b0;
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("out_hold", 32'(current_state), 6);
      chk("out_valid", 32'(result_valid), 1);
      imem_ack = (i == 2);
      #1;
      chk("out_ir_load", 32'(ir_load), 0);
      tick();
    end
    imem_ack = 1'b0;
    chk("out_still", 32'(current_state), 6);
    out_ready = 1'b1;
    tick();
    chk("out_to_if", 32'(current_state), 0);
    chk("out_retired", 32'(retired_count), 1);

    // MAX_INSTR=3 instance: three ADDIUs then HALT
    rst_h_n = 1'b1;
    run = 1'b1; imem_ack = 1'b1; out_ready = 1'b1; operation_code = 6'b001001;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 12) begin
        chk("h_mid_state", 32'(current_state_h), 0);
        chk("h_mid_retired", 32'(retired_count_h), 2);
      end
    end
    chk("h_state", 32'(current_state_h), 7);
    chk("h_halted", 32'(halted_h), 1);
    chk("h_retired", 32'(retired_count_h), 3);
    for (int i = 0; i < 6; i++) tick();
    chk("h_stays", 32'(current_state_h), 7);
    chk("h_retired_hold", 32'(retired_count_h), 3);
    chk("h_no_req", 32'({imem_req_h, ir_load_h}), 0);
    run = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
